// File: rtl/intlv_pkg.sv
// Shared types and parameter defaults for the convolutional interleaver commutator.
package intlv_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned NUM_BRANCH_DEF = 12;
    localparam int unsigned PKT_LEN_DEF    = 204;
    localparam logic [7:0]  SYNC_BYTE_DEF  = 8'h47;
    localparam int unsigned MISS_MAX_DEF   = 3;

endpackage

// File: rtl/intlv_branch_mux.sv
// Combinational NUM_BRANCH:1 byte selector over the packed delay-line outputs.
module intlv_branch_mux
    import intlv_pkg::*;
#(
    parameter int unsigned NUM_BRANCH = NUM_BRANCH_DEF,
    parameter int unsigned SEL_W      = (NUM_BRANCH > 1) ? $clog2(NUM_BRANCH) : 1
) (
    input  logic [8*NUM_BRANCH-1:0] branch_q,
    input  logic [SEL_W-1:0]        sel,
    output logic [7:0]              byte_c
);

    always_comb begin
        byte_c = '0;
        for (int j = 0; j < NUM_BRANCH; j++) begin
            if (sel == SEL_W'(j)) begin
                byte_c = branch_q[8*j +: 8];
            end
        end
    end

endmodule

// File: rtl/intlv_commutator.sv
// Input commutator of a byte-wise convolutional interleaver with sync-byte packet lock.
// Optional sync-loss detection is enabled by defining INTLV_SYNC_CHECK_EN.
module intlv_commutator
    import intlv_pkg::*;
#(
    parameter int unsigned NUM_BRANCH = NUM_BRANCH_DEF,
    parameter int unsigned PKT_LEN    = PKT_LEN_DEF,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int unsigned MISS_MAX   = MISS_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              data_in,
    input  logic                    valid_in,
    input  logic [8*NUM_BRANCH-1:0] branch_q,
    output logic [7:0]              branch_data,
    output logic [NUM_BRANCH-1:0]   branch_en,
    output logic [7:0]              data_out,
    output logic                    valid_out,
    output logic                    locked
);

    localparam int unsigned BW = (NUM_BRANCH > 1) ? $clog2(NUM_BRANCH) : 1;
    localparam int unsigned CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    state_t                  state_q, state_n;
    logic [BW-1:0]           idx_q, idx_n;
    logic [CW-1:0]           cnt_q, cnt_n;
    logic [7:0]              bdata_n, dout_n;
    logic [NUM_BRANCH-1:0]   ben_n;
    logic                    vout_n;
    logic                    accept;
    logic [7:0]              sel_byte_c;

`ifdef INTLV_SYNC_CHECK_EN
    localparam int unsigned MW = (MISS_MAX > 1) ? $clog2(MISS_MAX + 1) : 1;
    logic [MW-1:0]           miss_q, miss_n;
`endif

    intlv_branch_mux #(
        .NUM_BRANCH (NUM_BRANCH),
        .SEL_W      (BW)
    ) u_mux (
        .branch_q (branch_q),
        .sel      (idx_q),
        .byte_c   (sel_byte_c)
    );

    // Next-state and output decode
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        bdata_n = branch_data;
        dout_n  = data_out;
        ben_n   = '0;
        vout_n  = 1'b0;
        accept  = 1'b0;
`ifdef INTLV_SYNC_CHECK_EN
        miss_n  = miss_q;
`endif

        case (state_q)
            SEARCH: begin
                if (valid_in && (data_in == SYNC_BYTE)) begin
                    accept  = 1'b1;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (valid_in) begin
                    accept = 1'b1;
`ifdef INTLV_SYNC_CHECK_EN
                    // Packet start must carry the sync byte; too many misses drop lock
                    if (cnt_q == '0) begin
                        if (data_in != SYNC_BYTE) begin
                            if (miss_q == MW'(MISS_MAX - 1)) begin
                                accept  = 1'b0;
                                state_n = SEARCH;
                                miss_n  = '0;
                                idx_n   = '0;
                                cnt_n   = '0;
                            end else begin
                                miss_n = miss_q + MW'(1);
                            end
                        end else begin
                            miss_n = '0;
                        end
                    end
`endif
                end
            end
            default: state_n = SEARCH;
        endcase

        if (accept) begin
            for (int j = 0; j < NUM_BRANCH; j++) begin
                ben_n[j] = (idx_q == BW'(j));
            end
            bdata_n = data_in;
            dout_n  = sel_byte_c;
            vout_n  = 1'b1;
            idx_n   = (idx_q == BW'(NUM_BRANCH - 1)) ? '0 : idx_q + BW'(1);
            cnt_n   = (cnt_q == CW'(PKT_LEN - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            idx_q       <= '0;
            cnt_q       <= '0;
            branch_data <= '0;
            branch_en   <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            branch_data <= bdata_n;
            branch_en   <= ben_n;
            data_out    <= dout_n;
            valid_out   <= vout_n;
            locked      <= (state_n == LOCKED);
        end
    end

`ifdef INTLV_SYNC_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_n;
        end
    end
`endif

endmodule

// File: tb/tb_intlv_commutator.sv
// Randomized scoreboard bench for intlv_commutator against a packet-position reference model.
module tb_intlv_commutator;

    localparam int unsigned NB   = 12;
    localparam int unsigned PL   = 204;
    localparam logic [7:0]  SYNC = 8'h47;
    localparam int          MM   = 3;
`ifdef INTLV_SYNC_CHECK_EN
    localparam bit SYNC_CHK = 1'b1;
`else
    localparam bit SYNC_CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      data_in = '0;
    logic            valid_in = 1'b0;
    logic [8*NB-1:0] branch_q = '0;
    logic [7:0]      branch_data;
    logic [NB-1:0]   branch_en;
    logic [7:0]      data_out;
    logic            valid_out;
    logic            locked;

    always #5 clk = ~clk;

    intlv_commutator #(
        .NUM_BRANCH (NB),
        .PKT_LEN    (PL),
        .SYNC_BYTE  (SYNC),
        .MISS_MAX   (MM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .branch_q    (branch_q),
        .branch_data (branch_data),
        .branch_en   (branch_en),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .locked      (locked)
    );

    typedef struct packed {
        logic          v;
        logic [NB-1:0] en;
        logic [7:0]    bd;
        logic [7:0]    dout;
        logic          lk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: lock flag, position within packet, consecutive sync misses
    bit         m_lock = 1'b0;
    int         m_pos  = 0;
    int         m_miss = 0;
    logic [7:0] m_bd   = '0;
    logic [7:0] m_dout = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model(input bit v, input logic [7:0] d, input logic [8*NB-1:0] bq);
        exp_t e;
        bit   acc;
        int   b;
        acc = 1'b0;
        if (v) begin
            if (!m_lock) begin
                if (d == SYNC) begin
                    m_lock = 1'b1;
                    m_pos  = 0;
                    acc    = 1'b1;
                end
            end else begin
                acc = 1'b1;
                if (SYNC_CHK && m_pos == 0) begin
                    if (d != SYNC) begin
                        m_miss++;
                        if (m_miss >= MM) begin
                            m_lock = 1'b0;
                            m_miss = 0;
                            m_pos  = 0;
                            acc    = 1'b0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            end
        end
        e.en = '0;
        e.v  = acc;
        if (acc) begin
            b       = m_pos % NB;
            e.en[b] = 1'b1;
            m_bd    = d;
            m_dout  = bq[8*b +: 8];
            m_pos   = (m_pos + 1) % PL;
        end
        e.bd   = m_bd;
        e.dout = m_dout;
        e.lk   = m_lock;
        sb.push_back(e);
    endtask

    // Monitor: compare one expected response per clock, just after the edge
    exp_t got_e;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            chk("out{v,en,bd,dout,lk}",
                64'({valid_out, branch_en, branch_data, data_out, locked}), 64'(got_e));
        end
    end

    task automatic step(input bit v, input logic [7:0] d);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        for (int j = 0; j < NB; j++) branch_q[8*j +: 8] = 8'($urandom);
        model(v, d, branch_q);
    endtask

    function automatic logic [7:0] nonsync();
        logic [7:0] r;
        r = 8'($urandom);
        if (r == SYNC) r = ~r;
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d);
        while ($urandom_range(3) == 0) step(1'b0, 8'($urandom));
        step(1'b1, d);
    endtask

    task automatic send_pkt(input logic [7:0] first);
        for (int p = 0; p < int'(PL); p++) send_byte(p == 0 ? first : nonsync());
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_valid_out", 64'(valid_out), 64'(0));
        chk("rst_branch_en", 64'(branch_en), 64'(0));
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_branch_data", 64'(branch_data), 64'(0));
        sb.delete();
        m_lock = 1'b0; m_pos = 0; m_miss = 0; m_bd = '0; m_dout = '0;
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        // Search: junk dropped, sync accepted on branch 0
        step(1'b1, 8'h00);
        step(1'b1, 8'h12);
        step(1'b1, SYNC);
        // Back-to-back bytes walk all branches and wrap
        for (int i = 0; i < 13; i++) step(1'b1, nonsync());
        // Gap holds the branch index
        step(1'b1, nonsync());
        step(1'b0, nonsync());
        step(1'b1, nonsync());
        while (m_pos != 0) send_byte(nonsync());
        // Two clean packets
        send_pkt(SYNC);
        send_pkt(SYNC);
        // Three corrupted sync bytes, then a clean packet
        send_pkt(8'h48);
        send_pkt(8'hB8);
        send_pkt(8'h00);
        send_pkt(SYNC);
        // Reset mid-packet at byte 100
        while (m_pos != 100) send_byte(nonsync());
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, nonsync());
        send_pkt(SYNC);
        // Random traffic with occasional sync bytes
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(1)), ($urandom_range(15) == 0) ? SYNC : 8'($urandom));
        repeat (3) step(1'b0, 8'h00);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intlv_commutator.md
INTLV_COMMUTATOR -- requirements
Module: intlv_commutator

Interface
REQ-001 SHALL have parameter NUM_BRANCH, default 12: number of interleaver branches.
REQ-002 SHALL have parameter PKT_LEN, default 204: bytes per packet; PKT_LEN is a multiple of NUM_BRANCH.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'h47: packet sync value.
REQ-004 SHALL have parameter MISS_MAX, default 3: consecutive sync misses before lock is lost.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port data_in, input, 8: incoming byte.
REQ-008 SHALL have port valid_in, input, 1: data_in is valid this cycle.
REQ-009 SHALL have port branch_q, input, 8*NUM_BRANCH: delay-line outputs; byte j at bits [8j+7:8j].
REQ-010 SHALL have port branch_data, output, 8: byte written to the selected branch.
REQ-011 SHALL have port branch_en, output, NUM_BRANCH: one-hot shift enable for the branch delay lines.
REQ-012 SHALL have port data_out, output, 8: interleaved output byte.
REQ-013 SHALL have port valid_out, output, 1: data_out is valid.
REQ-014 SHALL have port locked, output, 1: sync lock status.

Function
REQ-015 SHALL implement two states: SEARCH and LOCKED.
REQ-016 In SEARCH, valid_in=1 with data_in==SYNC_BYTE SHALL be accepted as branch 0, byte 0, and the state SHALL go to LOCKED.
REQ-017 In SEARCH, all other bytes SHALL be dropped: branch_en=0, valid_out=0.
REQ-018 Each accepted byte at branch index b SHALL produce, on the next edge: branch_en = one-hot(b), branch_data = data_in, data_out = branch_q[b] (sampled in the accept cycle), and valid_out=1. Latency is 1 cycle.
REQ-019 When valid_in=0, the block SHALL hold its branch index, byte count and miss count, and SHALL drive branch_en=0 and valid_out=0 on the next edge.
REQ-020 After each accepted byte, the branch index SHALL increment and wrap NUM_BRANCH-1 -> 0; the byte count SHALL increment and wrap PKT_LEN-1 -> 0.
REQ-021 Byte 0 of every packet SHALL always map to branch 0.
REQ-022 locked SHALL be registered and equal 1 exactly while the state is LOCKED.
REQ-023 data_out SHALL hold its last value while valid_out=0.

Reset
REQ-024 While reset=0, all of the following SHALL be 0 immediately (asynchronously): state=SEARCH, branch index, byte count, miss count, branch_data, branch_en, data_out, valid_out and locked.
REQ-025 Reset asserted mid-packet SHALL discard the partial packet; after release the block SHALL resume in SEARCH.

Configuration
REQ-026 SHALL support macro INTLV_SYNC_CHECK_EN.
- Defined: in LOCKED, a byte accepted at byte count 0 that differs from SYNC_BYTE SHALL increment the miss count. A match SHALL clear the miss count.
- Defined: when the miss count reaches MISS_MAX, the state SHALL go to SEARCH on that edge, and that byte SHALL NOT be forwarded.
- Not defined: once LOCKED, the state SHALL remain LOCKED until reset, and the miss-count logic SHALL be absent.

Structure
REQ-027 Package intlv_pkg SHALL hold the state enum and the defaults for NUM_BRANCH, PKT_LEN, SYNC_BYTE and MISS_MAX.
REQ-028 The branch_q byte selection SHALL be a separate sub-module, intlv_branch_mux: NUM_BRANCH:1, 8-bit, combinational.

Verification
REQ-029 Reset release, then 0x00,0x12 then 0x47 valid -> no branch_en or valid_out until the cycle after 0x47; then branch_en=12'h001, branch_data=0x47, locked=1.
REQ-030 Locked, 13 consecutive valid bytes -> branch_en walks 001,002,...,800 then 001; data_out equals the matching branch_q slice, delayed 1 cycle.
REQ-031 valid_in toggled 1,0,1 -> enables only after valid cycles; the branch index does not advance across the gap.
REQ-032 With INTLV_SYNC_CHECK_EN, corrupt the sync byte of 3 consecutive packets -> locked drops on the third one; a clean 0x47 re-locks. Without the macro -> locked stays 1.
REQ-033 Assert reset at byte 100 of a packet -> outputs are 0 immediately; after release the block is in SEARCH and the next 0x47 maps to branch 0.
REQ-034 Two back-to-back 204-byte packets -> every sync byte lands on branch 0 and the miss count stays 0.
